// File: rtl/i2s_pkg.sv
// -----------------------------------------------------------------------------
// i2s_pkg
// Shared types and constants for the I2S capture path.
//   DATA_W_DEFAULT : default sample width (bits, MSB first on the wire)
//   CH_L / CH_R    : channel codes; they match the LRClk level (0 = left)
//   deser_state_t  : deserializer states WAIT_L / SHIFT / SKIP
//   wr_state_t     : SDRAM writer states IDLE / REQ / ACK
// -----------------------------------------------------------------------------
package i2s_pkg;

  localparam int unsigned DATA_W_DEFAULT = 16;

  localparam logic CH_L = 1'b0;
  localparam logic CH_R = 1'b1;

  typedef enum logic [1:0] {
    WAIT_L,
    SHIFT,
    SKIP
  } deser_state_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACK
  } wr_state_t;

endpackage

// File: rtl/sample_fifo.sv
// -----------------------------------------------------------------------------
// sample_fifo
// Single-clock FIFO with a registered occupancy count. It is cleared by reset.
// A push while full is ignored, and so is a pop while empty.
// Ports:
//   clk, rst     : clock and asynchronous active-high reset
//   push, din    : write strobe and data
//   pop          : read strobe; dout always shows the head entry
//   full, empty  : status flags
//   level        : number of occupied entries (0..DEPTH)
// -----------------------------------------------------------------------------
module sample_fifo #(
  parameter  int W     = 16,
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] level
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign level     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  // NOTE: the storage array is not reset. Clearing the pointers and the count is enough to empty the FIFO.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  // The pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/i2s_rx_capture.sv
// -----------------------------------------------------------------------------
// i2s_rx_capture
// Captures codec ADC samples in I2S format and writes them to an SDRAM ring.
// SClk, LRClk and Din are oversampled in the Clk50 domain. 16-bit words are
// deserialized with left/right alignment, buffered in sample_fifo, and written
// through the rd/wr-Wait-ac handshake.
// Ports:
//   Clk50, reset          : system clock, asynchronous active-high reset
//   SClk, LRClk, Din      : asynchronous codec bit clock, word clock, data
//   enable                : capture enable (level)
//   sdram_Wait, sdram_ac  : controller not-ready, write-accepted pulse
//   sdram_wr/_wdata/_addr : write request, data, word address
//   busy                  : a write transaction is in progress
//   overflow              : sticky sample-drop flag, cleared while enable=0
//   fifo_level            : occupied FIFO entries
// Build option: define I2S_RX_MONO_EN to store left-channel words only.
// -----------------------------------------------------------------------------
module i2s_rx_capture
  import i2s_pkg::*;
#(
  parameter int          DATA_W     = DATA_W_DEFAULT,
  parameter int          FIFO_DEPTH = 32,
  parameter logic [24:0] BASE_ADDR  = 25'h100000,
  parameter logic [24:0] RING_WORDS = 25'h40000
) (
  input  logic                          Clk50,
  input  logic                          reset,
  input  logic                          SClk,
  input  logic                          LRClk,
  input  logic                          Din,
  input  logic                          enable,
  input  logic                          sdram_Wait,
  input  logic                          sdram_ac,
  output logic                          sdram_wr,
  output logic [DATA_W-1:0]             sdram_wdata,
  output logic [24:0]                   sdram_addr,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

`ifdef I2S_RX_MONO_EN
  localparam bit MONO = 1'b1;
`else
  localparam bit MONO = 1'b0;
`endif

  localparam int          BW        = $clog2(DATA_W + 1);
  localparam logic [24:0] LAST_ADDR = BASE_ADDR + RING_WORDS - 25'd1;

  // ---------------------------------------------------------------------------
  // Synchronizers. SClk has an extra history stage for rise detection.
  // LR and Din are read from the same stage as the synced SClk, so all three
  // values describe the same instant.
  // ---------------------------------------------------------------------------
  logic [2:0] r_sclk_sync;
  logic [1:0] r_lr_sync;
  logic [1:0] r_din_sync;

  logic w_sclk_rise;
  logic w_lr;
  logic w_din;
  logic w_lr_changed;

  // NOTE: non-blocking assignment makes each stage take the previous stage's old value, so the chain really delays.
  always_ff @(posedge Clk50 or posedge reset) begin
    if (reset) begin
      r_sclk_sync <= '0;
      r_lr_sync   <= '0;
      r_din_sync  <= '0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[1:0], SClk};
      r_lr_sync   <= {r_lr_sync[0], LRClk};
      r_din_sync  <= {r_din_sync[0], Din};
    end
  end

  assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
  assign w_lr        = r_lr_sync[1];
  assign w_din       = r_din_sync[1];

  // ---------------------------------------------------------------------------
  // Deserializer
  // ---------------------------------------------------------------------------
  deser_state_t      r_ds_state;
  logic [DATA_W-1:0] r_shreg;
  logic [BW-1:0]     r_bitcnt;
  logic              r_chan;
  logic              r_lr_prev;     // LR value at the previous sclk_rise
  logic              r_push;
  logic [DATA_W-1:0] r_push_data;

  assign w_lr_changed = w_lr ^ r_lr_prev;

  always_ff @(posedge Clk50 or posedge reset) begin
    if (reset) begin
      r_ds_state  <= WAIT_L;
      r_shreg     <= '0;
      r_bitcnt    <= '0;
      r_chan      <= CH_L;
      r_lr_prev   <= CH_L;
      r_push      <= 1'b0;
      r_push_data <= '0;
    end else begin
      r_push <= 1'b0;
      if (w_sclk_rise) r_lr_prev <= w_lr;

      if (!enable) begin
        r_ds_state <= WAIT_L;
      end else if (w_sclk_rise) begin
        case (r_ds_state)
          // Start only on a right->left transition, so SDRAM always sees L first.
          WAIT_L: begin
            if (r_lr_prev == CH_R && w_lr == CH_L) begin
              r_bitcnt   <= '0;
              r_chan     <= CH_L;
              r_ds_state <= SHIFT;
            end
          end
          SHIFT: begin
            if (w_lr_changed) begin
              // This is the I2S delay bit. Any partial word restarts for the new channel.
              r_bitcnt <= '0;
              r_chan   <= w_lr;
            end else begin
              r_shreg  <= {r_shreg[DATA_W-2:0], w_din};
              r_bitcnt <= r_bitcnt + 1'b1;
              if (r_bitcnt == BW'(DATA_W - 1)) begin
                r_push      <= !MONO || (r_chan == CH_L);
                r_push_data <= {r_shreg[DATA_W-2:0], w_din};
                r_ds_state  <= SKIP;
              end
            end
          end
          SKIP: begin
            if (w_lr_changed) begin
              r_bitcnt   <= '0;
              r_chan     <= w_lr;
              r_ds_state <= SHIFT;
            end
          end
          default: r_ds_state <= WAIT_L;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sample FIFO
  // ---------------------------------------------------------------------------
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic [DATA_W-1:0] w_head;

  sample_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (Clk50),
    .rst   (reset),
    .push  (r_push),
    .pop   (w_pop),
    .din   (r_push_data),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (fifo_level)
  );

  logic r_overflow;

  always_ff @(posedge Clk50 or posedge reset) begin
    if (reset)                 r_overflow <= 1'b0;
    else if (!enable)          r_overflow <= 1'b0;
    else if (r_push && w_full) r_overflow <= 1'b1;
  end

  assign overflow = r_overflow;

  // ---------------------------------------------------------------------------
  // SDRAM writer: at least 3 cycles per word (IDLE -> REQ -> ACK)
  // ---------------------------------------------------------------------------
  wr_state_t         r_wr_state;
  logic              r_wr;
  logic              r_busy;
  logic [DATA_W-1:0] r_wdata;
  logic [24:0]       r_addr;

  assign w_pop = (r_wr_state == ACK);

  always_ff @(posedge Clk50 or posedge reset) begin
    if (reset) begin
      r_wr_state <= IDLE;
      r_wr       <= 1'b0;
      r_busy     <= 1'b0;
      r_wdata    <= '0;
      r_addr     <= BASE_ADDR;
    end else begin
      case (r_wr_state)
        IDLE: begin
          if (!w_empty && !sdram_Wait) begin
            r_wdata    <= w_head;
            r_wr       <= 1'b1;
            r_busy     <= 1'b1;
            r_wr_state <= REQ;
          end
        end
        REQ: begin
          if (sdram_ac) begin
            r_wr       <= 1'b0;
            r_wr_state <= ACK;
          end
        end
        ACK: begin
          r_addr     <= (r_addr == LAST_ADDR) ? BASE_ADDR : r_addr + 25'd1;
          r_busy     <= 1'b0;
          r_wr_state <= IDLE;
        end
        default: begin
          r_wr       <= 1'b0;
          r_busy     <= 1'b0;
          r_wr_state <= IDLE;
        end
      endcase
    end
  end

  assign sdram_wr    = r_wr;
  assign busy        = r_busy;
  assign sdram_wdata = r_wdata;
  assign sdram_addr  = r_addr;

endmodule

// File: tb/tb_i2s_rx_capture.sv
// -----------------------------------------------------------------------------
// tb_i2s_rx_capture
// Drives an I2S codec stream (32-bit slots, data changes on the falling SClk
// edge) into i2s_rx_capture and models the SDRAM slave. The expected write
// stream comes from a slot-level model: alignment on the first right->left
// slot boundary while enabled, drop-on-full while the SDRAM is stalled, and
// a ring address of BASE + (n mod RING). The ring is shortened so the wrap
// occurs many times within a short run.
// -----------------------------------------------------------------------------
module tb_i2s_rx_capture;
  import i2s_pkg::*;

  localparam logic [24:0] BASE  = 25'h100000;
  localparam logic [24:0] RING  = 25'd10;
  localparam int          DEPTH = 32;
`ifdef I2S_RX_MONO_EN
  localparam bit MONO = 1'b1;
`else
  localparam bit MONO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        sclk;
  logic        lrclk;
  logic        din;
  logic        enable;
  logic        wait_i;
  logic        ac;
  logic        wr;
  logic [15:0] wdata;
  logic [24:0] addr;
  logic        busy;
  logic        ovf;
  logic [5:0]  level;

  i2s_rx_capture #(
    .RING_WORDS (RING)
  ) dut (
    .Clk50       (clk),
    .reset       (rst),
    .SClk        (sclk),
    .LRClk       (lrclk),
    .Din         (din),
    .enable      (enable),
    .sdram_Wait  (wait_i),
    .sdram_ac    (ac),
    .sdram_wr    (wr),
    .sdram_wdata (wdata),
    .sdram_addr  (addr),
    .busy        (busy),
    .overflow    (ovf),
    .fifo_level  (level)
  );

  always #10ns clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- SDRAM slave ----------------
  bit          ack_hold = 1'b0;
  bit          in_req   = 1'b0;
  int unsigned ack_delay;
  logic [24:0] obs_addr_q[$];
  logic [15:0] obs_data_q[$];

  initial begin
    ac = 1'b0;
    forever begin
      @(negedge clk);
      if (ac) begin
        ac = 1'b0;
      end else if (wr && !ack_hold) begin
        if (!in_req) begin
          in_req    = 1'b1;
          ack_delay = $urandom_range(0, 3);
        end
        if (ack_delay == 0) begin
          obs_addr_q.push_back(addr);
          obs_data_q.push_back(wdata);
          ac     = 1'b1;
          in_req = 1'b0;
        end else begin
          ack_delay--;
        end
      end else if (!wr) begin
        in_req = 1'b0;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [15:0] exp_q[$];
  int          m_wcount;
  bit          m_aligned;
  logic        m_prev_ch;
  bit          m_stall;
  int          m_pending;
  bit          m_ovf;

  task automatic model_reset();
    exp_q.delete();
    m_wcount  = 0;
    m_aligned = 1'b0;
    m_prev_ch = CH_L;
    m_stall   = 1'b0;
    m_pending = 0;
    m_ovf     = 1'b0;
  endtask

  task automatic set_enable(input logic v);
    enable = v;
    if (!v) begin
      m_aligned = 1'b0;
      m_ovf     = 1'b0;
    end
  endtask

  // One slot as seen by the capture rules, evaluated at the slot start.
  task automatic model_slot(input logic ch, input logic [15:0] w);
    if (!enable) m_aligned = 1'b0;
    else if (ch == CH_L && m_prev_ch == CH_R) m_aligned = 1'b1;
    if (m_aligned && (!MONO || ch == CH_L)) begin
      if (m_stall && m_pending >= DEPTH) begin
        m_ovf = 1'b1;
      end else begin
        exp_q.push_back(w);
        if (m_stall) m_pending++;
      end
    end
    m_prev_ch = ch;
  endtask

  // ---------------- I2S BFM ----------------
  task automatic send_slot(input logic ch, input logic [15:0] w, input int en_bit);
    model_slot(ch, w);
    for (int i = 0; i < 32; i++) begin
      if (i == en_bit) set_enable(1'b1);
      lrclk = ch;
      din   = (i >= 1 && i <= 16) ? w[16-i] : 1'b0;
      #81ns sclk = 1'b1;
      #81ns sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    send_slot(CH_L, l, -1);
    send_slot(CH_R, r, -1);
  endtask

  // Wait for every expected write (bounded), then compare data and address in order.
  task automatic drain(input string tag);
    int budget = 20000;
    while (obs_data_q.size() < exp_q.size() && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    repeat (8) @(posedge clk);
    check({tag, "_count"}, 32'(obs_data_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_data_q.size() > 0) begin
      check({tag, "_data"}, 32'(obs_data_q.pop_front()), 32'(exp_q.pop_front()));
      check({tag, "_addr"}, 32'(obs_addr_q.pop_front()), 32'(BASE + 25'(m_wcount % int'(RING))));
      m_wcount++;
    end
    exp_q.delete();
    obs_data_q.delete();
    obs_addr_q.delete();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int budget;
    int frames;
    rst    = 1'b1;
    sclk   = 1'b0;
    lrclk  = 1'b1;
    din    = 1'b0;
    enable = 1'b0;
    wait_i = 1'b0;
    model_reset();

    #35ns;
    @(negedge clk);
    check("rst_wr",    32'(wr),    32'd0);
    check("rst_wdata", 32'(wdata), 32'd0);
    check("rst_addr",  32'(addr),  32'(BASE));
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_ovf",   32'(ovf),   32'd0);
    check("rst_level", 32'(level), 32'd0);
    rst = 1'b0;

    // Basic stereo frame, with a leading right slot to arm alignment.
    set_enable(1'b1);
    send_slot(CH_R, 16'hDEAD, -1);
    send_frame(16'hA5C3, 16'h1234);
    drain("t1");

    // Random stream with random ack latency
    for (int k = 0; k < 4; k++) send_frame(16'($urandom), 16'($urandom));
    drain("rand");

    // SDRAM stall: 40 samples into a 32-entry FIFO
    @(negedge clk);
    wait_i    = 1'b1;
    m_stall   = 1'b1;
    m_pending = 0;
    frames    = MONO ? 40 : 20;
    for (int k = 0; k < frames; k++) send_frame(16'($urandom), 16'($urandom));
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("stall_level", 32'(level), 32'(m_pending));
    check("stall_ovf",   32'(ovf),   32'(m_ovf));
    check("stall_wr",    32'(wr),    32'd0);
    check("stall_busy",  32'(busy),  32'd0);
    check("stall_nowr",  32'(obs_data_q.size()), 32'd0);
    wait_i  = 1'b0;
    m_stall = 1'b0;
    drain("stall");

    // enable=0 clears overflow
    set_enable(1'b0);
    repeat (2) @(negedge clk);
    check("dis_ovf", 32'(ovf), 32'(m_ovf));

    // enable rises in the middle of a right slot: capture starts at the next left
    send_slot(CH_L, 16'h0BAD, -1);
    send_slot(CH_R, 16'hBEEF, 10);
    send_frame(16'($urandom), 16'($urandom));
    send_frame(16'($urandom), 16'($urandom));
    drain("t2");

    // Short L/R sequence
    send_frame(16'd1, 16'd2);
    send_frame(16'd3, 16'd4);
    drain("t6");
    check("t6_ovf", 32'(ovf), 32'd0);

    // Reset while a request is pending
    ack_hold = 1'b1;
    send_frame(16'($urandom), 16'($urandom));
    budget = 200;
    while (!wr && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    @(negedge clk);
    check("t5_req_wr",   32'(wr),   32'd1);
    check("t5_req_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #3ns rst = 1'b1;
    #1ns;
    check("t5_wr",    32'(wr),    32'd0);
    check("t5_level", 32'(level), 32'd0);
    check("t5_addr",  32'(addr),  32'(BASE));
    check("t5_ovf",   32'(ovf),   32'd0);
    check("t5_busy",  32'(busy),  32'd0);
    model_reset();
    obs_data_q.delete();
    obs_addr_q.delete();
    ack_hold = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Restart after reset: addresses begin at BASE again
    send_slot(CH_R, 16'($urandom), -1);
    for (int k = 0; k < 3; k++) send_frame(16'($urandom), 16'($urandom));
    drain("post");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
